uart_rx_capture: RTL

- Synthesizable 8N1 UART receiver with a receive FIFO.
- Sits directly downstream of pulpino_top's uart_tx pin. Captures characters the core prints (stdout, "OK"/"ERROR" return strings) for on-board or emulation test harnesses that have no behavioural uart_bus.
- Exposes captured bytes through a ready/valid pop port plus sticky error flags.

---
 rtl/uart_rx_capture.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_capture.sv
// ---------------------------------------------------------------------------
// uart_rx_capture
//   8N1 UART receiver feeding a first-word-fall-through receive FIFO. Intended
//   to sit on a core's uart_tx pin and capture printed characters for test
//   harnesses that have no behavioural UART model.
//
//   Optional feature: define UART_RX_CAPTURE_PARITY_EN to add an even parity
//   bit after the eight data bits and the sticky parity_err_o output.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_i         asynchronous serial line, idle high
//   rx_en_i      receiver enable; low forces the FSM to IDLE
//   rd_data_o    FIFO head byte (registered)
//   rd_valid_o   FIFO not empty (registered)
//   rd_ready_i   pop request; pop = rd_valid_o & rd_ready_i
//   count_o      FIFO occupancy
//   frame_err_o  sticky: stop bit sampled low
//   overflow_o   sticky: byte dropped on a full FIFO
//   parity_err_o sticky: parity mismatch (UART_RX_CAPTURE_PARITY_EN only)
//   clr_err_i    synchronous clear of the sticky flags (a same-cycle set wins)
// ---------------------------------------------------------------------------
module uart_rx_capture #(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD_RATE   = 781250,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_i,
    input  logic                          rx_en_i,
    output logic [7:0]                    rd_data_o,
    output logic                          rd_valid_o,
    input  logic                          rd_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          frame_err_o,
    output logic                          overflow_o,
`ifdef UART_RX_CAPTURE_PARITY_EN
    output logic                          parity_err_o,
`endif
    input  logic                          clr_err_i
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   PTR_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   DEPTH_V  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
`ifdef UART_RX_CAPTURE_PARITY_EN
        ST_PARITY = 3'd5,
`endif
        ST_BREAK  = 3'd4
    } state_t;

`ifdef UART_RX_CAPTURE_PARITY_EN
    // Even parity: data plus parity bit must carry an even number of ones.
    function automatic logic parity_mismatch(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction
`endif

    // Synchronizer and edge-detect state
    logic r_rx_meta, r_rx_s, r_rx_prev;
    logic w_rx_fall;

    // Receive FSM state
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_push;
    logic [7:0]       r_push_data;
    logic             r_frame_err;
    logic             w_cnt_last;
    logic             w_par_bad;

    // FIFO state
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W:0]   r_wptr, r_rptr, r_count;
    logic [PTR_W:0]   w_rptr_nxt, w_count_nxt;
    logic [7:0]       r_rd_data;
    logic             r_rd_valid, r_overflow;
    logic             w_pop, w_full, w_push_ok;

`ifdef UART_RX_CAPTURE_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    assign w_par_bad    = r_par_bad;
    assign parity_err_o = r_parity_err;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_rx_fall  = r_rx_prev & ~r_rx_s;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    // Two-flop synchronizer on the line plus one delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // Receive FSM: frame sequencing, push request and line-error flags.
    // After the start-bit mid sample the counter restarts, so every later
    // sample lands one full bit period later, i.e. in the middle of each bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_push      <= 1'b0;
            r_push_data <= 8'h00;
            r_frame_err <= 1'b0;
`ifdef UART_RX_CAPTURE_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_push <= 1'b0;
            // Clear first; a set later in this block overrides it.
            if (clr_err_i) begin
                r_frame_err <= 1'b0;
`ifdef UART_RX_CAPTURE_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end
            if (!rx_en_i) begin
                r_state <= ST_IDLE;
                r_cnt   <= CNT_ZERO;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt <= CNT_ZERO;
                        if (w_rx_fall) r_state <= ST_START;
                    end
                    ST_START: begin
                        if (r_cnt == CNT_MID) begin
                            r_cnt     <= CNT_ZERO;
                            r_bit_idx <= 3'd0;
                            r_state   <= r_rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    ST_DATA: begin
                        if (w_cnt_last) begin
                            r_cnt     <= CNT_ZERO;
                            r_shift   <= {r_rx_s, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_CAPTURE_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
`ifdef UART_RX_CAPTURE_PARITY_EN
                    ST_PARITY: begin
                        if (w_cnt_last) begin
                            r_cnt     <= CNT_ZERO;
                            r_par_bad <= parity_mismatch(r_shift, r_rx_s);
                            r_state   <= ST_STOP;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (w_cnt_last) begin
                            r_cnt <= CNT_ZERO;
`ifdef UART_RX_CAPTURE_PARITY_EN
                            if (r_par_bad) r_parity_err <= 1'b1;
`endif
                            if (r_rx_s) begin
                                r_push      <= ~w_par_bad;
                                r_push_data <= r_shift;
                                r_state     <= ST_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_BREAK;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    ST_BREAK: begin
                        r_cnt <= CNT_ZERO;
                        if (r_rx_s) r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    // FIFO handshake decode; a full FIFO still accepts a push when it is
    // popped in the same cycle.
    always_comb begin
        w_pop      = r_rd_valid & rd_ready_i;
        w_full     = ((r_wptr - r_rptr) == DEPTH_V);
        w_push_ok  = r_push & (~w_full | w_pop);
        w_rptr_nxt = w_pop ? (r_rptr + PTR_ONE) : r_rptr;
        if (w_push_ok && !w_pop) begin
            w_count_nxt = r_count + PTR_ONE;
        end else if (!w_push_ok && w_pop) begin
            w_count_nxt = r_count - PTR_ONE;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[PTR_W-1:0]] <= r_push_data;
    end

    // FIFO pointers, registered head and overflow flag. The head is computed
    // from the write pointer before this cycle's push, which gives a new byte
    // one cycle in the FIFO before it is presented, while pops take effect on
    // the head immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= PTR_ZERO;
            r_rptr     <= PTR_ZERO;
            r_count    <= PTR_ZERO;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PTR_ONE;
            r_rptr     <= w_rptr_nxt;
            r_count    <= w_count_nxt;
            r_rd_valid <= (r_wptr != w_rptr_nxt);
            r_rd_data  <= (r_wptr != w_rptr_nxt) ? r_mem[w_rptr_nxt[PTR_W-1:0]] : 8'h00;
            if (r_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (clr_err_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_data_o   = r_rd_data;
    assign rd_valid_o  = r_rd_valid;
    assign count_o     = r_count;
    assign frame_err_o = r_frame_err;
    assign overflow_o  = r_overflow;

endmodule
